spart_mmio_bridge: RTL
======================

# spart_mmio_bridge

Memory-mapped I/O slave that sits directly downstream of the data-cache master port and services its polled SPART accesses. It decodes the status register (28'h8000001) and data register (28'h8000000), buffers received bytes in an RX FIFO and outgoing bytes in a TX FIFO, and answers each request with a one-cycle ready pulse. On the other side it exchanges bytes with the SPART transmitter and receiver.

## Interface
- RX_DEPTH, 4: RX FIFO entries (power of two, ≥2)
- TX_DEPTH, 4: TX FIFO entries (power of two, ≥2)
- RESP_LATENCY, 1: cycles from request acceptance to ready pulse (≥1)
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- mem_valid_data1  input  1  request valid from master, held until ready seen
- mem_rw_data1  input  1  1 = write, 0 = read
- mem_data_addr1  input  28  request address
- mem_data_wr1  input  32  write data (bits [7:0] used)
- mem_ready_data1  output  1  one-cycle completion pulse
- mem_data_rd1  output  32  read data, valid while ready is high
- rx_data  input  8  byte from SPART receiver
- rx_valid  input  1  one-cycle strobe, rx_data valid
- tx_data  output  8  TX FIFO head byte
- tx_valid  output  1  TX FIFO not empty
- tx_ready  input  1  SPART transmitter accepts tx_data when tx_valid && tx_ready

## Operation
- Status register (28'h8000001), read: bit0 = TX FIFO not full, bit1 = RX FIFO not empty, bit2 = sticky RX overrun, bit3 = sticky TX overrun, bits [31:4] = 0. Status read clears bits 2 and 3 at the ack edge. Status write: acked, no effect.
- Data register (28'h8000000), read: returns {24'b0, RX head} and pops. On empty RX: returns 0, no pop. Data write: pushes mem_data_wr1[7:0] into TX. On full TX: byte dropped, bit3 set.
- Any other address: read returns 32'h0, write ignored, ack always given.
- RX push on rx_valid. On full FIFO the byte is dropped and bit2 is set, unless a data-register pop commits in the same cycle, in which case both succeed.
- TX pop on tx_valid && tx_ready. A simultaneous push to a full TX FIFO succeeds when the pop commits in the same cycle.
- FSM states:
  - IDLE: on mem_valid_data1, capture rw/addr/wdata and go to BUSY.
  - BUSY: count RESP_LATENCY−1 cycles (0 means exit after one cycle), then go to ACK. Read data is registered on the BUSY→ACK edge.
  - ACK: mem_ready_data1=1 for exactly one cycle. FIFO pop/push and sticky clear commit at the end of this cycle. Go to DRAIN.
  - DRAIN: wait until mem_valid_data1=0, then go to IDLE. This prevents one request from being accepted twice.

## Timing
- Reset values: mem_ready_data1=0, mem_data_rd1=0, tx_valid=0, tx_data=0. Both FIFOs empty, sticky bits 0, FSM IDLE.
- Reset asserted mid-transaction: the transaction is aborted, no ack is issued, and FIFO contents are lost.
- With RESP_LATENCY=1: valid sampled at edge N, ready high in cycle N+2, back in IDLE at N+4 at the earliest.
- mem_data_rd1 holds its last value outside ACK.
- Status is sampled one cycle before ACK. An rx_valid in the ACK cycle is reflected in the next poll.
- FIFO pointers carry one extra wrap bit. Full = MSBs differ and index bits equal.
- tx_data is combinational from the FIFO head and stable while tx_valid is high and tx_ready is low.

## Structure
- Package spart_mmio_pkg holds:
  - SPART_DATA_ADDR = 28'h8000000, SPART_STAT_ADDR = 28'h8000001
  - status bit indices STAT_TX_RDY=0, STAT_RX_AVL=1, STAT_RX_OVR=2, STAT_TX_OVR=3
  - FSM state enum {IDLE, BUSY, ACK, DRAIN}
- Sub-module byte_fifo (parameter DEPTH; push, pop, din, dout, full, empty), instantiated once for RX and once for TX.

## Test plan
- Empty RX, status read → mem_data_rd1=32'h00000001, exactly one ready pulse, FSM back in IDLE.
- rx_valid with 8'hA5, then status read then data read → status 32'h00000003; data 32'h000000A5; a second status read returns 32'h00000001.
- Six rx bytes 8'h01..8'h06 with RX_DEPTH=4 → status 32'h00000007; data reads return 01,02,03,04 then 0; bit2 clears after the status read.
- tx_ready=0, five data writes 8'h10..8'h14 → bit0 drops after the fourth write; fifth byte dropped and bit3 set. With tx_ready=1, tx_data sequence is 10,11,12,13.
- Full RX with rx_valid in the same cycle as a data-read ACK → pop and push both succeed, no overrun flag.
- Read of 28'h0000123 → 32'h0 with a single ready pulse. rst_n asserted during BUSY → no ready pulse, all outputs at reset values.

Source files
------------

// File: rtl/spart_mmio_pkg.sv
// Shared definitions for the SPART MMIO bridge: register map, status bits, FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package spart_mmio_pkg;

  localparam logic [27:0] SPART_DATA_ADDR = 28'h8000000;
  localparam logic [27:0] SPART_STAT_ADDR = 28'h8000001;

  localparam int STAT_TX_RDY = 0;
  localparam int STAT_RX_AVL = 1;
  localparam int STAT_RX_OVR = 2;
  localparam int STAT_TX_OVR = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/spart_mmio_bridge_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; dout is the combinational head (0 when empty).
// Latency: a pushed byte is visible at dout the cycle after the push edge.
// Backpressure: push on full is accepted only when a pop commits in the same cycle, else ignored.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Gate the head so stale storage never leaks out after reset or when drained.
  assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  // Advance pointers for committed push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers; resetting them discards the stored contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spart_mmio_bridge.sv
// MMIO slave bridging dcache polled accesses to SPART RX/TX byte FIFOs with status/data registers.
// Latency: ready pulse RESP_LATENCY+1 cycles after the request is sampled; then waits for valid to drop.
// Backpressure: one request at a time; TX full drops writes (sticky flag), RX full drops bytes (sticky flag).
module spart_mmio_bridge
  import spart_mmio_pkg::*;
#(
  parameter int RX_DEPTH     = 4,
  parameter int TX_DEPTH     = 4,
  parameter int RESP_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid_data1,
  input  logic        mem_rw_data1,
  input  logic [27:0] mem_data_addr1,
  input  logic [31:0] mem_data_wr1,
  output logic        mem_ready_data1,
  output logic [31:0] mem_data_rd1,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CW = $clog2(RESP_LATENCY) + 1;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          rw_q;
  logic [27:0]   addr_q;
  logic [7:0]    wdata_q;
  logic [31:0]   rd_data_q;
  logic          ready_q;
  logic          pop_pend_q;
  logic          rx_ovr_q, rx_ovr_d;
  logic          tx_ovr_q, tx_ovr_d;

  logic        rx_full, rx_empty, rx_pop;
  logic [7:0]  rx_dout;
  logic        tx_full, tx_empty, tx_push, tx_pop;
  logic        is_data, is_stat, ack, stat_clr;
  logic [31:0] status_word;
  logic [31:0] rd_value;
  logic [23:0] unused_wr_hi;

  assign unused_wr_hi = mem_data_wr1[31:8];

  assign is_data  = (addr_q == SPART_DATA_ADDR);
  assign is_stat  = (addr_q == SPART_STAT_ADDR);
  assign ack      = (state_q == ACK);
  // Pop only if the ACK is returning a byte that was captured at BUSY exit.
  assign rx_pop   = ack && pop_pend_q;
  assign tx_push  = ack && rw_q && is_data;
  assign tx_pop   = !tx_empty && tx_ready;
  assign stat_clr = ack && !rw_q && is_stat;

  assign tx_valid        = !tx_empty;
  assign mem_ready_data1 = ready_q;
  assign mem_data_rd1    = rd_data_q;

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (wdata_q),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Build the status word and the read value for the captured request.
  always_comb begin
    status_word              = '0;
    status_word[STAT_TX_RDY] = !tx_full;
    status_word[STAT_RX_AVL] = !rx_empty;
    status_word[STAT_RX_OVR] = rx_ovr_q;
    status_word[STAT_TX_OVR] = tx_ovr_q;
    rd_value                 = '0;
    if (!rw_q) begin
      if (is_stat)      rd_value = status_word;
      else if (is_data) rd_value = {24'h0, rx_dout};
    end
  end

  // Sticky overrun flags; a new overrun wins over a same-cycle status clear.
  always_comb begin
    rx_ovr_d = rx_ovr_q;
    tx_ovr_d = tx_ovr_q;
    if (stat_clr) begin
      rx_ovr_d = 1'b0;
      tx_ovr_d = 1'b0;
    end
    if (rx_valid && rx_full && !rx_pop) rx_ovr_d = 1'b1;
    if (tx_push && tx_full && !tx_pop)  tx_ovr_d = 1'b1;
  end

  // Sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ovr_q <= 1'b0;
      tx_ovr_q <= 1'b0;
    end else begin
      rx_ovr_q <= rx_ovr_d;
      tx_ovr_q <= tx_ovr_d;
    end
  end

  // Request FSM with registered ready pulse and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      ready_q    <= 1'b0;
      pop_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_valid_data1) begin
            rw_q    <= mem_rw_data1;
            addr_q  <= mem_data_addr1;
            wdata_q <= mem_data_wr1[7:0];
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == CW'(RESP_LATENCY - 1)) begin
            state_q    <= ACK;
            ready_q    <= 1'b1;
            rd_data_q  <= rd_value;
            pop_pend_q <= !rw_q && is_data && !rx_empty;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ACK: begin
          ready_q    <= 1'b0;
          pop_pend_q <= 1'b0;
          state_q    <= DRAIN;
        end
        DRAIN: begin
          if (!mem_valid_data1) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
